test_sig_sweep: RTL

//  Upstream controller for the 4-lane DDS test-signal generator.
//  - Steps the phase increment through a programmed sweep: f_start + k*f_step, k = 0..n_steps-1.
//  - Holds each tone for a fixed dwell time.
//  - Drives pinc/poff/resync/valid_in of the generator and pulses resync at every tone change.
//  - Optional looping for continuous sweeps; single-shot otherwise.

---
 rtl/test_sig_pkg.sv | 20 ++
 rtl/test_sig_sweep_if.sv | 34 +++
 rtl/sweep_dwell_cnt.sv | 31 +++
 rtl/test_sig_sweep.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/test_sig_pkg.sv
// Shared types and widths for the DDS test-signal sweep controller and its users.
package test_sig_pkg;

   localparam int unsigned PHASE_W = 20;
   localparam int unsigned STEP_W  = 16;
   localparam int unsigned DWELL_W = 24;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      DWELL  = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Counter reload value for a tone: max(dwell,1)-1
   function automatic logic [DWELL_W-1:0] dwell_m1(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : d - DWELL_W'(1);
   endfunction

endpackage

// File: rtl/test_sig_sweep_if.sv
// Control/config inputs and generator-facing outputs of the sweep controller.
interface test_sig_sweep_if;
   import test_sig_pkg::*;

   logic               start;
   logic               stop;
   logic               loop_en;
   logic [PHASE_W-1:0] f_start;
   logic [PHASE_W-1:0] f_step;
   logic [STEP_W-1:0]  n_steps;
   logic [DWELL_W-1:0] dwell;
   logic [PHASE_W-1:0] poff_in;

   logic [PHASE_W-1:0] pinc;
   logic [PHASE_W-1:0] poff;
   logic               resync;
   logic               valid_out;
   logic               busy;
   logic               done;
   logic [STEP_W-1:0]  step_idx;

   // Sweep controller side: drives the generator stream
   modport master (
      input  start, stop, loop_en, f_start, f_step, n_steps, dwell, poff_in,
      output pinc, poff, resync, valid_out, busy, done, step_idx
   );

   // Host side: programs and launches sweeps
   modport slave (
      output start, stop, loop_en, f_start, f_step, n_steps, dwell, poff_in,
      input  pinc, poff, resync, valid_out, busy, done, step_idx
   );

endinterface

// File: rtl/sweep_dwell_cnt.sv
// Loadable down-counter; zero is registered alongside the count.
module sweep_dwell_cnt
   import test_sig_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   input  logic               en,
   output logic               zero
);

   logic [DWELL_W-1:0] r_cnt;
   logic               r_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_zero <= 1'b1;
      end else if (load) begin
         r_cnt  <= load_val;
         r_zero <= (load_val == '0);
      end else if (en && (r_cnt != '0)) begin
         r_cnt  <= r_cnt - DWELL_W'(1);
         r_zero <= (r_cnt == DWELL_W'(1));
      end
   end

   assign zero = r_zero;

endmodule

// File: rtl/test_sig_sweep.sv
// Sweep controller for the 4-lane DDS generator: steps pinc through
// f_start + k*f_step, holding each tone for max(dwell,1) cycles.
module test_sig_sweep
   import test_sig_pkg::*;
(
   input  logic              m_axis_aclk,
   input  logic              m_axis_areset,
   test_sig_sweep_if.master  bus
);

   state_t             r_state, w_state_nxt;

   logic [PHASE_W-1:0] r_f_start, w_f_start_nxt;
   logic [PHASE_W-1:0] r_f_step, w_f_step_nxt;
   logic [STEP_W-1:0]  r_n_steps, w_n_steps_nxt;
   logic [DWELL_W-1:0] r_dwell_m1, w_dwell_m1_nxt;

   logic [PHASE_W-1:0] r_pinc, w_pinc_nxt;
   logic [PHASE_W-1:0] r_poff, w_poff_nxt;
   logic [STEP_W-1:0]  r_step_idx, w_step_nxt;
   logic               r_resync, w_resync_nxt;
   logic               r_run, w_run_nxt;
   logic               r_done, w_done_nxt;

   logic               w_cnt_load, w_cnt_en, w_cnt_zero;
   logic [DWELL_W-1:0] w_cnt_val;
   logic               w_last;

   assign w_last = (r_step_idx == (r_n_steps - STEP_W'(1)));

   sweep_dwell_cnt u_cnt (
      .clk      (m_axis_aclk),
      .rst      (m_axis_areset),
      .load     (w_cnt_load),
      .load_val (w_cnt_val),
      .en       (w_cnt_en),
      .zero     (w_cnt_zero)
   );

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) r_state <= IDLE;
      else               r_state <= w_state_nxt;
   end

   // Stop overrides every transition, including a start or a step advance
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:   if (bus.start && (bus.n_steps != '0)) w_state_nxt = LOAD;
         LOAD,
         DWELL:  if (w_cnt_zero && w_last && !bus.loop_en) w_state_nxt = FINISH;
                 else                                      w_state_nxt = DWELL;
         FINISH: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (bus.stop) w_state_nxt = IDLE;
   end

   // Next values of the registered outputs; loop_en is taken live at each wrap
   always_comb begin
      w_f_start_nxt  = r_f_start;
      w_f_step_nxt   = r_f_step;
      w_n_steps_nxt  = r_n_steps;
      w_dwell_m1_nxt = r_dwell_m1;
      w_pinc_nxt     = r_pinc;
      w_poff_nxt     = r_poff;
      w_step_nxt     = r_step_idx;
      w_resync_nxt   = 1'b0;
      w_done_nxt     = 1'b0;
      w_cnt_load     = 1'b0;
      w_cnt_en       = 1'b0;
      w_cnt_val      = r_dwell_m1;
      w_run_nxt      = (w_state_nxt == LOAD) || (w_state_nxt == DWELL);
      if (!bus.stop) begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.n_steps == '0) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_f_start_nxt  = bus.f_start;
                     w_f_step_nxt   = bus.f_step;
                     w_n_steps_nxt  = bus.n_steps;
                     w_dwell_m1_nxt = dwell_m1(bus.dwell);
                     w_pinc_nxt     = bus.f_start;
                     w_poff_nxt     = bus.poff_in;
                     w_step_nxt     = '0;
                     w_resync_nxt   = 1'b1;
                     w_cnt_load     = 1'b1;
                     w_cnt_val      = dwell_m1(bus.dwell);
                  end
               end
            end
            LOAD, DWELL: begin
               if (w_cnt_zero) begin
                  if (!w_last) begin
                     w_pinc_nxt   = r_pinc + r_f_step;
                     w_step_nxt   = r_step_idx + STEP_W'(1);
                     w_resync_nxt = 1'b1;
                     w_cnt_load   = 1'b1;
                  end else if (bus.loop_en) begin
                     w_pinc_nxt   = r_f_start;
                     w_step_nxt   = '0;
                     w_resync_nxt = 1'b1;
                     w_cnt_load   = 1'b1;
                  end
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
            FINISH:  w_done_nxt = 1'b0;
            default: w_done_nxt = 1'b0;
         endcase
         if (r_state == FINISH) w_done_nxt = 1'b0;
      end
   end

   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         r_f_start  <= '0;
         r_f_step   <= '0;
         r_n_steps  <= '0;
         r_dwell_m1 <= '0;
         r_pinc     <= '0;
         r_poff     <= '0;
         r_step_idx <= '0;
         r_resync   <= 1'b0;
         r_run      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_f_start  <= w_f_start_nxt;
         r_f_step   <= w_f_step_nxt;
         r_n_steps  <= w_n_steps_nxt;
         r_dwell_m1 <= w_dwell_m1_nxt;
         r_pinc     <= w_pinc_nxt;
         r_poff     <= w_poff_nxt;
         r_step_idx <= w_step_nxt;
         r_resync   <= w_resync_nxt;
         r_run      <= w_run_nxt;
         r_done     <= w_done_nxt || ((w_state_nxt == FINISH) && !bus.stop);
      end
   end

   assign bus.pinc      = r_pinc;
   assign bus.poff      = r_poff;
   assign bus.step_idx  = r_step_idx;
   assign bus.resync    = r_resync;
   assign bus.valid_out = r_run;
   assign bus.busy      = r_run;
   assign bus.done      = r_done;

endmodule
